// File: rtl/irq_gateway_pkg.sv
// irq_gateway_pkg: shared definitions for the external interrupt gateway.
//   DEFAULT_EXT_IRQ_COUNT : default number of external lines
//   irq_mode_e            : trigger-mode encodings (level = 0, rising edge = 1)
//   line_state_e          : per-line pending latch states
//   irq_id_w(n)           : width of a line index, max(1, clog2(n))
package irq_gateway_pkg;

  localparam int unsigned DEFAULT_EXT_IRQ_COUNT = 4;

  typedef enum logic {
    IRQ_MODE_LEVEL = 1'b0,
    IRQ_MODE_EDGE  = 1'b1
  } irq_mode_e;

  typedef enum logic {
    LINE_IDLE    = 1'b0,
    LINE_PENDING = 1'b1
  } line_state_e;

  function automatic int unsigned irq_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_gateway_if.sv
// irq_gateway_if: line, mask, acknowledge and pending signals of the gateway.
//   irq_in        raw external lines, asynchronous to clk
//   irq_edge_mode per line: 1 = rising edge, 0 = high level
//   irq_enable    per-line mask applied to irq_bus only
//   ack_valid     one line acknowledged this cycle
//   ack_id        index of the acknowledged line
//   irq_pending   raw pending latches (unmasked)
//   irq_bus       irq_pending & irq_enable, to the interrupt controller
// Modports: master = stimulus/core side, slave = gateway side.
interface irq_gateway_if
  import irq_gateway_pkg::*;
#(
  parameter int unsigned EXT_IRQ_COUNT = DEFAULT_EXT_IRQ_COUNT
);
  localparam int unsigned IDW = irq_id_w(EXT_IRQ_COUNT);

  logic [EXT_IRQ_COUNT-1:0] irq_in;
  logic [EXT_IRQ_COUNT-1:0] irq_edge_mode;
  logic [EXT_IRQ_COUNT-1:0] irq_enable;
  logic                     ack_valid;
  logic [IDW-1:0]           ack_id;
  logic [EXT_IRQ_COUNT-1:0] irq_pending;
  logic [EXT_IRQ_COUNT-1:0] irq_bus;

  modport master (
    output irq_in, irq_edge_mode, irq_enable, ack_valid, ack_id,
    input  irq_pending, irq_bus
  );

  modport slave (
    input  irq_in, irq_edge_mode, irq_enable, ack_valid, ack_id,
    output irq_pending, irq_bus
  );

endinterface

// File: rtl/irq_line_cell.sv
// irq_line_cell: one external interrupt line.
//   Synchroniser (SYNC_STAGES flops), optional glitch filter, edge/level
//   trigger and an IDLE/PENDING latch cleared by a decoded acknowledge.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   irq_in      raw asynchronous line
//   edge_mode   1 = rising-edge trigger, 0 = high-level trigger
//   clear       acknowledge addressed to this line
//   pending     latch state (1 = PENDING)
// Build option: IRQ_FILTER_EN inserts a FILTER_CYCLES-sample stability
// filter between the synchroniser and the trigger logic.
module irq_line_cell
  import irq_gateway_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic edge_mode,
  input  logic clear,
  output logic pending
);

  if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_param_err
    $error("irq_line_cell: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   f;
  logic                   prev;
  logic                   trig;
  line_state_e            state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
    end
  end

  always_comb s = sync_q[SYNC_STAGES-1];

`ifdef IRQ_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // f follows s only after s has disagreed with f for FILTER_CYCLES
  // consecutive samples; any return to agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f   <= 1'b0;
      cnt <= '0;
    end else if (s != f) begin
      if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
        f   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  always_comb f = s;
`endif

  always_comb trig = (edge_mode == IRQ_MODE_EDGE) ? (f & ~prev) : f;

  // Set has priority over clear: a level source still asserted at
  // acknowledge time re-pends without an idle gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= 1'b0;
      state <= LINE_IDLE;
    end else begin
      prev <= f;
      if (trig) begin
        state <= LINE_PENDING;
      end else if (clear) begin
        state <= LINE_IDLE;
      end
    end
  end

  always_comb pending = (state == LINE_PENDING);

endmodule

// File: rtl/irq_gateway.sv
// irq_gateway: front end for external interrupt lines ahead of the
// interrupt controller. Each line is synchronised, triggered (edge or level)
// and held pending until acknowledged; irq_bus is the enabled subset.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   irq    irq_gateway_if.slave (irq_in, irq_edge_mode, irq_enable,
//          ack_valid, ack_id, irq_pending, irq_bus)
// Parameters: EXT_IRQ_COUNT (1..32), SYNC_STAGES (>= 2),
//   FILTER_CYCLES (>= 1, used only when IRQ_FILTER_EN is defined).
// Build option: IRQ_FILTER_EN enables the per-line glitch filter.
module irq_gateway
  import irq_gateway_pkg::*;
#(
  parameter int unsigned EXT_IRQ_COUNT = DEFAULT_EXT_IRQ_COUNT,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  irq_gateway_if.slave irq
);

  localparam int unsigned IDW = irq_id_w(EXT_IRQ_COUNT);

  if (EXT_IRQ_COUNT < 1 || EXT_IRQ_COUNT > 32) begin : g_count_err
    $error("irq_gateway: EXT_IRQ_COUNT must be in 1..32");
  end

  logic [EXT_IRQ_COUNT-1:0] clear;
  logic [EXT_IRQ_COUNT-1:0] pending;

  // Indices with no matching line simply decode to an all-zero vector.
  always_comb begin
    clear = '0;
    if (irq.ack_valid) begin
      for (int unsigned i = 0; i < EXT_IRQ_COUNT; i++) begin
        if (irq.ack_id == IDW'(i)) begin
          clear[i] = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < EXT_IRQ_COUNT; i++) begin : g_line
    irq_line_cell #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .irq_in   (irq.irq_in[i]),
      .edge_mode(irq.irq_edge_mode[i]),
      .clear    (clear[i]),
      .pending  (pending[i])
    );
  end

  always_comb begin
    irq.irq_pending = pending;
    irq.irq_bus     = pending & irq.irq_enable;
  end

endmodule
